// File: rtl/ram_loader.sv
// Byte-stream boot loader: 16-bit word count, then big-endian words written to RAM port B
// while the CPU is held in reset. Optional trailing XOR checksum under LOADER_CHECKSUM_EN.
module ram_loader #(
    parameter logic [9:0] BASE_ADDR = 10'd0,
    parameter int         MAX_WORDS = 1024
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic [7:0]  byte_in,
    input  logic        byte_valid,
    output logic        byte_ready,
    output logic [9:0]  addr_b,
    output logic [15:0] data_b,
    output logic        we_b,
    output logic        cpu_hold,
    output logic        done,
    output logic        err
);

`ifdef LOADER_CHECKSUM_EN
    typedef enum logic [2:0] {CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, CHECK, DONE} stateType;
`else
    typedef enum logic [2:0] {CNT_HI, CNT_LO, DAT_HI, DAT_LO, WRITE, DONE} stateType;
`endif

    localparam logic [16:0] MaxWords = 17'(MAX_WORDS);

    stateType    stateReg;
    logic [7:0]  hiByteReg;
    logic [15:0] countReg;
    logic [15:0] wordIdxReg;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  xorReg;
`endif

    logic        accept;
    logic [15:0] wordCount;
    logic        lastWord;

    assign accept    = byte_valid & byte_ready;
    assign wordCount = {hiByteReg, byte_in};
    assign lastWord  = (wordIdxReg + 16'd1) >= countReg;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            stateReg   <= CNT_HI;
            hiByteReg  <= 8'd0;
            countReg   <= 16'd0;
            wordIdxReg <= 16'd0;
            addr_b     <= BASE_ADDR;
            data_b     <= 16'd0;
            we_b       <= 1'b0;
            byte_ready <= 1'b1;
            cpu_hold   <= 1'b1;
            done       <= 1'b0;
            err        <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            xorReg     <= 8'd0;
`endif
        end else begin
            case (stateReg)
                CNT_HI: if (accept) begin
                    hiByteReg <= byte_in;
                    stateReg  <= CNT_LO;
                end
                CNT_LO: if (accept) begin
                    if (wordCount == 16'd0 || {1'b0, wordCount} > MaxWords) begin
                        stateReg   <= DONE;
                        byte_ready <= 1'b0;
                        done       <= 1'b1;
                        err        <= 1'b1;
                    end else begin
                        countReg <= wordCount;
                        stateReg <= DAT_HI;
                    end
                end
                DAT_HI: if (accept) begin
                    hiByteReg <= byte_in;
                    stateReg  <= DAT_LO;
                end
                DAT_LO: if (accept) begin
                    // 10-bit sum wraps naturally past the top of the RAM
                    addr_b     <= BASE_ADDR + wordIdxReg[9:0];
                    data_b     <= wordCount;
                    we_b       <= 1'b1;
                    byte_ready <= 1'b0;
                    stateReg   <= WRITE;
`ifdef LOADER_CHECKSUM_EN
                    xorReg     <= xorReg ^ hiByteReg ^ byte_in;
`endif
                end
                WRITE: begin
                    we_b       <= 1'b0;
                    wordIdxReg <= wordIdxReg + 16'd1;
                    if (!lastWord) begin
                        byte_ready <= 1'b1;
                        stateReg   <= DAT_HI;
                    end else begin
`ifdef LOADER_CHECKSUM_EN
                        byte_ready <= 1'b1;
                        stateReg   <= CHECK;
`else
                        stateReg   <= DONE;
                        done       <= 1'b1;
                        err        <= 1'b0;
                        cpu_hold   <= 1'b0;
`endif
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                CHECK: if (accept) begin
                    stateReg   <= DONE;
                    byte_ready <= 1'b0;
                    done       <= 1'b1;
                    err        <= (byte_in != xorReg);
                    cpu_hold   <= (byte_in != xorReg);
                end
`endif
                DONE: if (start) begin
                    stateReg   <= CNT_HI;
                    byte_ready <= 1'b1;
                    cpu_hold   <= 1'b1;
                    done       <= 1'b0;
                    err        <= 1'b0;
                    wordIdxReg <= 16'd0;
`ifdef LOADER_CHECKSUM_EN
                    xorReg     <= 8'd0;
`endif
                end
                default: begin
                    stateReg   <= CNT_HI;
                    byte_ready <= 1'b1;
                    we_b       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Scoreboard bench for ram_loader: two instances (base 0 and base 1023) share one byte stream.
// Checksum bytes are only sent when LOADER_CHECKSUM_EN is defined.
module tb_ram_loader;

    logic        Clk;
    logic        Rst;
    logic        start;
    logic [7:0]  byteIn;
    logic        byteValid;

    logic        rdy0, we0, hold0, done0, err0;
    logic [9:0]  addr0;
    logic [15:0] data0;
    logic        rdy1, we1, hold1, done1, err1;
    logic [9:0]  addr1;
    logic [15:0] data1;

    int passCount  = 0;
    int checkCount = 0;

    logic [25:0] exp0[$];
    logic [25:0] exp1[$];
    logic [25:0] e0, e1;
    logic [7:0]  sumAcc;

    ram_loader #(.BASE_ADDR(10'd0), .MAX_WORDS(1024)) dut0 (
        .Clk(Clk), .Rst(Rst), .start(start), .byte_in(byteIn), .byte_valid(byteValid),
        .byte_ready(rdy0), .addr_b(addr0), .data_b(data0), .we_b(we0),
        .cpu_hold(hold0), .done(done0), .err(err0)
    );

    ram_loader #(.BASE_ADDR(10'd1023), .MAX_WORDS(1024)) dut1 (
        .Clk(Clk), .Rst(Rst), .start(start), .byte_in(byteIn), .byte_valid(byteValid),
        .byte_ready(rdy1), .addr_b(addr1), .data_b(data1), .we_b(we1),
        .cpu_hold(hold1), .done(done1), .err(err1)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checkCount++;
        if (obs === expv) passCount++;
        else $display("FAIL %s: got %h expected %h", tag, obs, expv);
    endtask

    task automatic pushWord(input int k, input logic [15:0] d);
        exp0.push_back({10'(k % 1024), d});
        exp1.push_back({10'((1023 + k) % 1024), d});
        sumAcc = sumAcc ^ d[15:8] ^ d[7:0];
    endtask

    // Called at a falling edge; returns at the falling edge after the byte was taken.
    task automatic sendByte(input logic [7:0] b);
        int n = 0;
        byteIn    = b;
        byteValid = 1'b1;
        while (!rdy0 && n < 50) begin
            @(negedge Clk);
            n++;
        end
        if (n >= 50) check("rdyTimeout", 32'(rdy0), 32'd1);
        @(negedge Clk);
    endtask

    task automatic sendSum(input logic [7:0] b);
`ifdef LOADER_CHECKSUM_EN
        sendByte(b);
`else
        if (b == 8'hxx) $display("unused checksum byte");
`endif
    endtask

    task automatic idle();
        byteValid = 1'b0;
    endtask

    task automatic waitDone();
        int n = 0;
        while (!done0 && n < 50) begin
            @(negedge Clk);
            n++;
        end
    endtask

    task automatic checkDone(input logic expErr);
        check("done0", 32'(done0), 32'd1);
        check("done1", 32'(done1), 32'd1);
        check("err0", 32'(err0), 32'(expErr));
        check("err1", 32'(err1), 32'(expErr));
        check("hold0", 32'(hold0), 32'(expErr));
        check("hold1", 32'(hold1), 32'(expErr));
        check("rdyDone0", 32'(rdy0), 32'd0);
        check("sbLeft0", 32'(exp0.size()), 32'd0);
        check("sbLeft1", 32'(exp1.size()), 32'd0);
    endtask

    task automatic restart();
        start = 1'b1;
        @(negedge Clk);
        start  = 1'b0;
        sumAcc = 8'd0;
        check("doneClr", 32'(done0), 32'd0);
        check("errClr", 32'(err0), 32'd0);
        check("holdSet", 32'(hold0), 32'd1);
        check("rdyRestart", 32'(rdy0), 32'd1);
    endtask

    always @(negedge Clk) begin
        if (we0) begin
            $display("dut0 write addr=%h data=%h", addr0, data0);
            if (exp0.size() == 0) check("wr0Extra", 32'(we0), 32'd0);
            else begin
                e0 = exp0.pop_front();
                check("wr0", {6'd0, addr0, data0}, {6'd0, e0});
            end
            check("rdyWr0", 32'(rdy0), 32'd0);
        end
        if (we1) begin
            $display("dut1 write addr=%h data=%h", addr1, data1);
            if (exp1.size() == 0) check("wr1Extra", 32'(we1), 32'd0);
            else begin
                e1 = exp1.pop_front();
                check("wr1", {6'd0, addr1, data1}, {6'd0, e1});
            end
            check("rdyWr1", 32'(rdy1), 32'd0);
        end
    end

    initial begin
        logic [15:0] w;
        Rst = 1'b0; start = 1'b0; byteIn = 8'd0; byteValid = 1'b0; sumAcc = 8'd0;
        repeat (2) @(negedge Clk);
        check("rstRdy", 32'(rdy0), 32'd1);
        check("rstWe", 32'(we0), 32'd0);
        check("rstAddr0", 32'(addr0), 32'd0);
        check("rstAddr1", 32'(addr1), 32'd1023);
        check("rstData", 32'(data0), 32'd0);
        check("rstHold", 32'(hold0), 32'd1);
        check("rstDone", 32'(done0), 32'd0);
        check("rstErr", 32'(err0), 32'd0);
        Rst = 1'b1;
        @(negedge Clk);

        // basic load; start toggled mid-load must be ignored
        pushWord(0, 16'h1234); pushWord(1, 16'hABCD);
        sendByte(8'h00); sendByte(8'h02);
        start = 1'b1;
        sendByte(8'h12); sendByte(8'h34);
        start = 1'b0;
        sendByte(8'hAB); sendByte(8'hCD);
        sendSum(8'h40);
        idle(); waitDone(); checkDone(1'b0);

        // zero count
        restart();
        sendByte(8'h00); sendByte(8'h00);
        idle(); waitDone(); checkDone(1'b1);

        // count above MAX_WORDS
        restart();
        sendByte(8'h04); sendByte(8'h01);
        idle(); waitDone(); checkDone(1'b1);

        // address wrap (dut1 writes 1023 then 0)
        restart();
        pushWord(0, 16'h0001); pushWord(1, 16'h0002);
        sendByte(8'h00); sendByte(8'h02);
        sendByte(8'h00); sendByte(8'h01); sendByte(8'h00); sendByte(8'h02);
        sendSum(8'h03);
        idle(); waitDone(); checkDone(1'b0);

        // back-pressure: byte_valid never drops during the stream
        restart();
        sendByte(8'h00); sendByte(8'h04);
        for (int k = 0; k < 4; k++) begin
            w = 16'($urandom);
            pushWord(k, w);
            sendByte(w[15:8]); sendByte(w[7:0]);
        end
        sendSum(sumAcc);
        idle(); waitDone(); checkDone(1'b0);

        // reset must act between clock edges
        #2 Rst = 1'b0;
        #1;
        check("asyncDone", 32'(done0), 32'd0);
        check("asyncHold", 32'(hold0), 32'd1);
        check("asyncRdy", 32'(rdy0), 32'd1);
        check("asyncAddr1", 32'(addr1), 32'd1023);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);

        // reset after first data high byte: no write, then a clean reload
        sendByte(8'h00); sendByte(8'h02); sendByte(8'h12);
        idle();
        #2 Rst = 1'b0;
        #1 check("midRstWe", 32'(we0), 32'd0);
        @(negedge Clk);
        Rst = 1'b1;
        @(negedge Clk);
        check("midRstWeAfter", 32'(we0), 32'd0);
        sumAcc = 8'd0;
        pushWord(0, 16'h55AA);
        sendByte(8'h00); sendByte(8'h01); sendByte(8'h55); sendByte(8'hAA);
        sendSum(8'hFF);
        idle(); waitDone(); checkDone(1'b0);

`ifdef LOADER_CHECKSUM_EN
        restart();
        pushWord(0, 16'h1234);
        sendByte(8'h00); sendByte(8'h01); sendByte(8'h12); sendByte(8'h34); sendByte(8'h26);
        idle(); waitDone(); checkDone(1'b0);

        restart();
        pushWord(0, 16'h1234);
        sendByte(8'h00); sendByte(8'h01); sendByte(8'h12); sendByte(8'h34); sendByte(8'h27);
        idle(); waitDone(); checkDone(1'b1);
`endif

        repeat (3) @(negedge Clk);
        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule
